wbu_pipeline: RTL and testbench

Write-back stage of the in-order pipeline, consuming the LSU stage output. Retires one instruction per accepted handshake and performs these actions:
- drives the integer register-file write port;
- owns the machine-mode CSR file (mstatus, mtvec, mepc, mcause, mcycle, minstret) and performs CSR writes;
- resolves ecall/mret by issuing a PC redirect plus pipeline flush;
- halts the core on ebreak.

Also provides the combinational CSR read port used by EXU.

---
 rtl/riscv_csr_pkg.sv | 30 +++
 rtl/csr_file_m.sv | 81 ++++++++
 rtl/wbu_pipeline.sv | 121 ++++++++++++
 tb/tb_wbu_pipeline.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_csr_pkg.sv
// Machine-mode CSR addresses, mstatus field positions, cause codes and the
// write-back stage state type shared by the write-back stage and its CSR file.
package riscv_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
   localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
   localparam logic [31:0] MARCHID_VAL   = 32'h0000_0000;

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } wbu_state_e;

endpackage

// File: rtl/csr_file_m.sv
// Machine-mode CSR registers, 64-bit cycle/instret counters and the
// combinational read mux. Trap updates take precedence over software writes.
module csr_file_m
   import riscv_csr_pkg::*;
#(
   parameter logic [31:0] RESET_MSTATUS  = 32'h0000_1800,
   parameter logic [31:0] MCAUSE_ECALL_M = CAUSE_ECALL_M
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_en,
   input  logic        retire,
   input  logic        do_ecall,
   input  logic        do_mret,
   input  logic        csr_we,
   input  logic [11:0] csr_waddr,
   input  logic [31:0] csr_wdata,
   input  logic [31:0] trap_pc,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic [31:0] mtvec,
   output logic [31:0] mepc
);

   logic [31:0] mstatus;
   logic [31:0] mcause;
   logic [63:0] mcycle;
   logic [63:0] minstret;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus  <= RESET_MSTATUS;
         mtvec    <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (count_en) mcycle <= mcycle + 64'd1;
         if (retire) minstret <= minstret + 64'd1;
         if (do_ecall) begin
            mepc                                 <= trap_pc;
            mcause                               <= MCAUSE_ECALL_M;
            mstatus[MSTATUS_MPIE]                <= mstatus[MSTATUS_MIE];
            mstatus[MSTATUS_MIE]                 <= 1'b0;
            mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
         end else if (do_mret) begin
            mstatus[MSTATUS_MIE]                 <= mstatus[MSTATUS_MPIE];
            mstatus[MSTATUS_MPIE]                <= 1'b1;
            mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b00;
         end else if (csr_we) begin
            // counters and unknown addresses silently drop the write
            case (csr_waddr)
               CSR_MSTATUS: mstatus <= csr_wdata;
               CSR_MTVEC:   mtvec   <= csr_wdata;
               CSR_MEPC:    mepc    <= csr_wdata;
               CSR_MCAUSE:  mcause  <= csr_wdata;
               default:     ;
            endcase
         end
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         CSR_MSTATUS:   csr_rdata = mstatus;
         CSR_MTVEC:     csr_rdata = mtvec;
         CSR_MEPC:      csr_rdata = mepc;
         CSR_MCAUSE:    csr_rdata = mcause;
         CSR_MCYCLE:    csr_rdata = mcycle[31:0];
         CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
         CSR_MINSTRET:  csr_rdata = minstret[31:0];
         CSR_MINSTRETH: csr_rdata = minstret[63:32];
         CSR_MVENDORID: csr_rdata = MVENDORID_VAL;
         CSR_MARCHID:   csr_rdata = MARCHID_VAL;
         default:       csr_rdata = '0;
      endcase
   end

endmodule

// File: rtl/wbu_pipeline.sv
// Write-back stage: retires LSU results into the register file, resolves
// ecall/mret redirects, halts on ebreak and hosts the machine CSR file.
module wbu_pipeline
   import riscv_csr_pkg::*;
#(
   parameter logic [31:0] RESET_MSTATUS  = 32'h0000_1800,
   parameter logic [31:0] MCAUSE_ECALL_M = 32'd11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_result,
   input  logic [4:0]  in_rd,
   input  logic        in_reg_wen,
   input  logic        in_csr_wen,
   input  logic [11:0] in_csr_addr,
   input  logic [31:0] in_csr_wdata,
   input  logic        in_ecall,
   input  logic        in_mret,
   input  logic        in_ebreak,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        commit_valid,
   output logic [31:0] commit_pc,
   output logic [31:0] commit_inst,
   output logic        halt,
   output logic [31:0] halt_pc,
   output logic        dbg_state
);

   // Handshake: an instruction is taken on a rising clk edge where
   // in_valid && in_ready; in_ready depends only on state, never on in_valid.
   wbu_state_e  state_q, state_d;
   logic        accept, do_ecall, do_mret, do_ebreak, csr_we;
   logic [31:0] mtvec, mepc;

   assign accept    = in_valid && in_ready;
   assign do_ebreak = accept && in_ebreak;
   assign do_ecall  = accept && in_ecall && !in_ebreak;
   assign do_mret   = accept && in_mret && !in_ebreak && !in_ecall;
   assign csr_we    = accept && in_csr_wen && !do_ecall && !do_mret;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == S_RUN && do_ebreak) state_d = S_HALT;
   end

   always_comb begin
      in_ready  = !rst && (state_q == S_RUN);
      dbg_state = state_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wen         <= 1'b0;
         rf_waddr       <= '0;
         rf_wdata       <= '0;
         commit_valid   <= 1'b0;
         commit_pc      <= '0;
         commit_inst    <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
         halt           <= 1'b0;
         halt_pc        <= '0;
      end else begin
         rf_wen         <= accept && in_reg_wen && (in_rd != 5'd0);
         commit_valid   <= accept;
         redirect_valid <= do_ecall || do_mret;
         flush          <= do_ecall || do_mret;
         if (accept) begin
            rf_waddr    <= in_rd;
            rf_wdata    <= in_result;
            commit_pc   <= in_pc;
            commit_inst <= in_inst;
         end
         // targets are sampled before the CSR file updates at this edge
         if (do_ecall)     redirect_pc <= mtvec;
         else if (do_mret) redirect_pc <= mepc;
         if (do_ebreak) begin
            halt    <= 1'b1;
            halt_pc <= in_pc;
         end
      end
   end

   csr_file_m #(
      .RESET_MSTATUS (RESET_MSTATUS),
      .MCAUSE_ECALL_M(MCAUSE_ECALL_M)
   ) u_csr (
      .clk      (clk),
      .rst      (rst),
      .count_en (state_q == S_RUN),
      .retire   (accept),
      .do_ecall (do_ecall),
      .do_mret  (do_mret),
      .csr_we   (csr_we),
      .csr_waddr(in_csr_addr),
      .csr_wdata(in_csr_wdata),
      .trap_pc  (in_pc),
      .csr_raddr(csr_raddr),
      .csr_rdata(csr_rdata),
      .mtvec    (mtvec),
      .mepc     (mepc)
   );

endmodule

// File: tb/tb_wbu_pipeline.sv
// Bench for wbu_pipeline: architectural model of retire/trap/CSR behaviour,
// per-cycle compare against it, and literal checks for the directed cases.
module tb_wbu_pipeline;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0, in_inst = '0, in_result = '0;
   logic [4:0]  in_rd = '0;
   logic        in_reg_wen = 1'b0, in_csr_wen = 1'b0;
   logic [11:0] in_csr_addr = '0;
   logic [31:0] in_csr_wdata = '0;
   logic        in_ecall = 1'b0, in_mret = 1'b0, in_ebreak = 1'b0;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [11:0] csr_raddr = 12'h300;
   logic [31:0] csr_rdata;
   logic        redirect_valid, flush, commit_valid, halt, dbg_state;
   logic [31:0] redirect_pc, commit_pc, commit_inst, halt_pc;

   int n_checks = 0;
   int n_pass   = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   wbu_pipeline dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_result(in_result), .in_rd(in_rd),
      .in_reg_wen(in_reg_wen), .in_csr_wen(in_csr_wen), .in_csr_addr(in_csr_addr),
      .in_csr_wdata(in_csr_wdata), .in_ecall(in_ecall), .in_mret(in_mret),
      .in_ebreak(in_ebreak), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_inst(commit_inst), .halt(halt), .halt_pc(halt_pc),
      .dbg_state(dbg_state)
   );

   // ---------------- architectural model ----------------
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
   logic [63:0] m_mcycle, m_minstret;
   logic        m_halted;
   logic        e_rf_wen, e_commit, e_redir;
   logic [4:0]  e_rf_waddr;
   logic [31:0] e_rf_wdata, e_commit_pc, e_commit_inst, e_redir_pc, e_halt_pc;

   function automatic logic [31:0] model_csr(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'hB00: return m_mcycle[31:0];
         12'hB80: return m_mcycle[63:32];
         12'hB02: return m_minstret[31:0];
         12'hB82: return m_minstret[63:32];
         12'hF11: return 32'h7973_7978;
         default: return 32'h0;
      endcase
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
         m_mcycle = 0; m_minstret = 0; m_halted = 0;
         e_rf_wen = 0; e_commit = 0; e_redir = 0; e_halt_pc = 0;
         e_rf_waddr = 0; e_rf_wdata = 0; e_commit_pc = 0; e_commit_inst = 0;
         e_redir_pc = 0;
      end else begin
         logic run, mie, mpie, trap;
         run = !m_halted;
         e_rf_wen = 0; e_commit = 0; e_redir = 0;
         if (run) m_mcycle = m_mcycle + 1;
         if (run && in_valid) begin
            e_commit = 1; e_commit_pc = in_pc; e_commit_inst = in_inst;
            e_rf_wen = in_reg_wen && in_rd != 0;
            e_rf_waddr = in_rd; e_rf_wdata = in_result;
            m_minstret = m_minstret + 1;
            mie  = m_mstatus[3];
            mpie = m_mstatus[7];
            trap = !in_ebreak && (in_ecall || in_mret);
            if (in_ebreak) begin
               m_halted = 1; e_halt_pc = in_pc;
            end else if (in_ecall) begin
               e_redir = 1; e_redir_pc = m_mtvec;
               m_mepc = in_pc; m_mcause = 11;
               m_mstatus = (m_mstatus & ~32'h0000_1888) | ({31'b0, mie} << 7) | (32'd3 << 11);
            end else if (in_mret) begin
               e_redir = 1; e_redir_pc = m_mepc;
               m_mstatus = (m_mstatus & ~32'h0000_1888) | ({31'b0, mpie} << 3) | (32'd1 << 7);
            end
            if (in_csr_wen && !trap) begin
               if (in_csr_addr == 12'h300) m_mstatus = in_csr_wdata;
               if (in_csr_addr == 12'h305) m_mtvec = in_csr_wdata;
               if (in_csr_addr == 12'h341) m_mepc = in_csr_wdata;
               if (in_csr_addr == 12'h342) m_mcause = in_csr_wdata;
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      else n_pass++;
   endtask

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("in_ready", in_ready, !rst && !m_halted);
         check("rf_wen", rf_wen, e_rf_wen);
         if (e_rf_wen) begin
            check("rf_waddr", rf_waddr, e_rf_waddr);
            check("rf_wdata", rf_wdata, e_rf_wdata);
         end
         check("commit_valid", commit_valid, e_commit);
         if (e_commit) begin
            check("commit_pc", commit_pc, e_commit_pc);
            check("commit_inst", commit_inst, e_commit_inst);
         end
         check("redirect_valid", redirect_valid, e_redir);
         check("flush", flush, e_redir);
         if (e_redir) check("redirect_pc", redirect_pc, e_redir_pc);
         check("halt", halt, m_halted);
         check("halt_pc", halt_pc, e_halt_pc);
         check("csr_rdata", csr_rdata, model_csr(csr_raddr));
      end
   end

   // ---------------- drivers ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] result, input logic [4:0] rd,
                        input logic reg_wen, input logic csr_wen,
                        input logic [11:0] caddr, input logic [31:0] cwdata,
                        input logic ecall, input logic mret, input logic ebreak);
      in_valid = 1; in_pc = pc; in_inst = inst; in_result = result; in_rd = rd;
      in_reg_wen = reg_wen; in_csr_wen = csr_wen; in_csr_addr = caddr;
      in_csr_wdata = cwdata; in_ecall = ecall; in_mret = mret; in_ebreak = ebreak;
      @(posedge clk);
      #2;
      in_valid = 0; in_reg_wen = 0; in_csr_wen = 0;
      in_ecall = 0; in_mret = 0; in_ebreak = 0;
   endtask

   task automatic read_csr(input logic [11:0] a, input string name, input logic [31:0] exp);
      csr_raddr = a;
      #1;
      check(name, csr_rdata, exp);
   endtask

   initial begin
      @(posedge clk);
      #2;
      chk_en = 1;
      check("rst_in_ready", in_ready, 0);
      check("rst_commit", commit_valid, 0);
      idle(2);
      rst = 0;
      #1;
      check("rel_in_ready", in_ready, 1);
      read_csr(12'h300, "rst_mstatus", 32'h1800);
      read_csr(12'hF11, "mvendorid", 32'h7973_7978);
      read_csr(12'hF12, "marchid", 32'h0);
      idle(1);

      // ALU retire
      drive(32'h8000_0000, 32'h0000_0013, 32'h1234, 5'd5, 1, 0, 0, 0, 0, 0, 0);
      check("alu_rf_wen", rf_wen, 1);
      check("alu_waddr", rf_waddr, 5);
      check("alu_wdata", rf_wdata, 32'h1234);
      check("alu_commit_pc", commit_pc, 32'h8000_0000);
      idle(1);
      check("alu_rf_wen_drop", rf_wen, 0);

      // x0 destination is masked but still commits
      drive(32'h8000_0004, 32'h0000_0013, 32'hFFFF, 5'd0, 1, 0, 0, 0, 0, 0, 0);
      check("x0_rf_wen", rf_wen, 0);
      check("x0_commit", commit_valid, 1);
      read_csr(12'hB02, "minstret_2", 32'd2);

      // CSR writes, ignored counter and unknown writes
      drive(32'h8000_0008, 32'h0, 32'h0, 5'd1, 1, 1, 12'h305, 32'h8000_0100, 0, 0, 0);
      read_csr(12'h305, "mtvec_wr", 32'h8000_0100);
      drive(32'h8000_000C, 32'h0, 32'h0, 5'd0, 0, 1, 12'h300, 32'h0000_1808, 0, 0, 0);
      drive(32'h8000_0010, 32'h0, 32'h0, 5'd0, 0, 1, 12'hB02, 32'h5555_0000, 0, 0, 0);
      drive(32'h8000_0014, 32'h0, 32'h0, 5'd0, 0, 1, 12'h123, 32'hAAAA_AAAA, 0, 0, 0);
      read_csr(12'hB02, "minstret_nowr", 32'd6);
      read_csr(12'h300, "mstatus_wr", 32'h1808);
      idle(1);

      // ecall with a CSR write that must be dropped
      drive(32'h8000_0040, 32'h0000_0073, 32'h0, 5'd0, 0, 1, 12'h305, 32'hDEAD_0000, 1, 0, 0);
      check("ecall_redir", redirect_valid, 1);
      check("ecall_flush", flush, 1);
      check("ecall_pc", redirect_pc, 32'h8000_0100);
      read_csr(12'h300, "ecall_mstatus", 32'h1880);
      read_csr(12'h341, "ecall_mepc", 32'h8000_0040);
      read_csr(12'h342, "ecall_mcause", 32'd11);
      read_csr(12'h305, "ecall_mtvec_kept", 32'h8000_0100);
      idle(1);
      check("ecall_flush_drop", flush, 0);

      // mret
      drive(32'h8000_0100, 32'h3020_0073, 32'h0, 5'd0, 0, 0, 0, 0, 0, 1, 0);
      check("mret_pc", redirect_pc, 32'h8000_0040);
      check("mret_flush", flush, 1);
      read_csr(12'h300, "mret_mstatus", 32'h0088);
      idle(1);

      // ecall and mret together: ecall wins
      drive(32'h8000_0060, 32'h0000_0073, 32'h0, 5'd0, 0, 0, 0, 0, 1, 1, 0);
      check("prio_pc", redirect_pc, 32'h8000_0100);
      read_csr(12'h341, "prio_mepc", 32'h8000_0060);
      read_csr(12'h300, "prio_mstatus", 32'h1880);

      // back-to-back retires with mixed content
      for (int i = 0; i < 8; i++) begin
         csr_raddr = (i % 2 == 0) ? 12'h341 : 12'hB00;
         drive(32'h8000_0200 + 32'(4 * i), $urandom, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               (i % 3 == 0) ? 12'h341 : 12'hB00, $urandom, 0, 0, 0);
      end
      idle(2);

      // ebreak halts; later requests are ignored and mcycle freezes
      drive(32'h8000_0080, 32'h0010_0073, 32'h77, 5'd3, 1, 0, 0, 0, 0, 0, 1);
      check("ebreak_halt", halt, 1);
      check("ebreak_halt_pc", halt_pc, 32'h8000_0080);
      check("ebreak_in_ready", in_ready, 0);
      check("ebreak_commit", commit_valid, 1);
      check("ebreak_state", dbg_state, 1);
      csr_raddr = 12'hB00;
      for (int i = 0; i < 3; i++) begin
         drive(32'h8000_0090, 32'h0, 32'h99, 5'd4, 1, 1, 12'h305, 32'h1, 0, 0, 0);
         check("halt_no_commit", commit_valid, 0);
         check("halt_no_rf", rf_wen, 0);
      end
      idle(3);
      rst = 1;
      idle(1);
      rst = 0;
      #1;
      check("post_rst_ready", in_ready, 1);
      check("post_rst_halt", halt, 0);

      // asynchronous reset in the middle of a strobe
      idle(1);
      drive(32'h8000_0000, 32'h0, 32'h42, 5'd7, 1, 1, 12'h300, 32'h0, 0, 0, 0);
      rst = 1;
      #1;
      check("arst_rf_wen", rf_wen, 0);
      check("arst_commit", commit_valid, 0);
      read_csr(12'h300, "arst_mstatus", 32'h1800);
      idle(1);
      rst = 0;
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
